// File: rtl/sdram_stream_arbiter_pkg.sv
// rtl/sdram_stream_arbiter_pkg.sv - shared types and constants for the SDRAM stream arbiter
package sdram_arb_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_CMD,
      S_RD_DATA,
      S_WR_BURST,
      S_DONE
   } state_t;

   localparam logic [1:0] ID_FB   = 2'd0;
   localparam logic [1:0] ID_MIPI = 2'd1;
   localparam logic [1:0] ID_CPU  = 2'd2;

   // Burst count must be able to hold the burst length itself, hence the +1.
   function automatic int burst_bits(input int burst);
      return $clog2(burst) + 1;
   endfunction

endpackage

// File: rtl/sdram_stream_arbiter_if.sv
// rtl/sdram_stream_arbiter_if.sv - requester and memory-master signal bundle
interface sdram_stream_arbiter_if #(
   parameter int ADDR_BITS = 22,
   parameter int DATA_BITS = 16,
   parameter int BURST     = 16
);
   import sdram_arb_pkg::*;

   localparam int BC_BITS = burst_bits(BURST);

   // framebuffer reader
   logic                 fb_req;
   logic                 fb_urgent;
   logic [ADDR_BITS-1:0] fb_addr;
   logic                 fb_gnt;
   logic                 fb_done;
   logic [DATA_BITS-1:0] fb_rddata;
   logic                 fb_rdvalid;

   // camera writer
   logic                 mipi_req;
   logic [ADDR_BITS-1:0] mipi_addr;
   logic [DATA_BITS-1:0] mipi_wrdata;
   logic                 mipi_gnt;
   logic                 mipi_wrack;
   logic                 mipi_done;

   // cpu single-word port
   logic                 cpu_req;
   logic                 cpu_write;
   logic [ADDR_BITS-1:0] cpu_addr;
   logic [DATA_BITS-1:0] cpu_wrdata;
   logic [DATA_BITS-1:0] cpu_rddata;
   logic                 cpu_done;

   // memory controller port
   logic [ADDR_BITS-1:0] mem_addr;
   logic [BC_BITS-1:0]   mem_burstcount;
   logic                 mem_read;
   logic                 mem_write;
   logic [DATA_BITS-1:0] mem_wrdata;
   logic                 mem_wait;
   logic [DATA_BITS-1:0] mem_rddata;
   logic                 mem_rdvalid;

   // arbiter side
   modport master (
      input  fb_req, fb_urgent, fb_addr,
      output fb_gnt, fb_done, fb_rddata, fb_rdvalid,
      input  mipi_req, mipi_addr, mipi_wrdata,
      output mipi_gnt, mipi_wrack, mipi_done,
      input  cpu_req, cpu_write, cpu_addr, cpu_wrdata,
      output cpu_rddata, cpu_done,
      output mem_addr, mem_burstcount, mem_read, mem_write, mem_wrdata,
      input  mem_wait, mem_rddata, mem_rdvalid
   );

   // requesters plus memory controller side
   modport slave (
      output fb_req, fb_urgent, fb_addr,
      input  fb_gnt, fb_done, fb_rddata, fb_rdvalid,
      output mipi_req, mipi_addr, mipi_wrdata,
      input  mipi_gnt, mipi_wrack, mipi_done,
      output cpu_req, cpu_write, cpu_addr, cpu_wrdata,
      input  cpu_rddata, cpu_done,
      input  mem_addr, mem_burstcount, mem_read, mem_write, mem_wrdata,
      output mem_wait, mem_rddata, mem_rdvalid
   );

endinterface

// File: rtl/sdram_stream_arbiter_picker.sv
// rtl/sdram_stream_arbiter_picker.sv - 3-way round-robin picker with FB urgent override
module rr_picker3
   import sdram_arb_pkg::*;
(
   input  logic [2:0] req,
   input  logic       urgent,
   input  logic [1:0] ptr,
   output logic [2:0] gnt
);

   // One-hot winner: urgent FB first, otherwise search starting at ptr.
   always_comb begin
      gnt = '0;
      if (urgent && req[ID_FB]) begin
         gnt[ID_FB] = 1'b1;
      end else begin
         case (ptr)
            ID_MIPI: begin
               if (req[ID_MIPI])     gnt[ID_MIPI] = 1'b1;
               else if (req[ID_CPU]) gnt[ID_CPU]  = 1'b1;
               else if (req[ID_FB])  gnt[ID_FB]   = 1'b1;
            end
            ID_CPU: begin
               if (req[ID_CPU])       gnt[ID_CPU]  = 1'b1;
               else if (req[ID_FB])   gnt[ID_FB]   = 1'b1;
               else if (req[ID_MIPI]) gnt[ID_MIPI] = 1'b1;
            end
            default: begin
               if (req[ID_FB])        gnt[ID_FB]   = 1'b1;
               else if (req[ID_MIPI]) gnt[ID_MIPI] = 1'b1;
               else if (req[ID_CPU])  gnt[ID_CPU]  = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/sdram_stream_arbiter.sv
// rtl/sdram_stream_arbiter.sv - per-transaction arbiter of FB, MIPI and CPU onto one SDRAM master
module sdram_stream_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_BITS = 22,
   parameter int DATA_BITS = 16,
   parameter int BURST     = 16
) (
   input logic clk,
   input logic rst,
   sdram_stream_arbiter_if.master bus
);

   localparam int BC_BITS = burst_bits(BURST);
   localparam logic [BC_BITS-1:0] BC_FULL = BC_BITS'(BURST);
   localparam logic [BC_BITS-1:0] BC_ONE  = BC_BITS'(1);

   state_t               state, state_nx;
   logic [1:0]           owner;
   logic [1:0]           ptr;
   logic [ADDR_BITS-1:0] addr_q;
   logic [BC_BITS-1:0]   bc_q;
   logic [BC_BITS-1:0]   count_q, count_nx;
   logic [DATA_BITS-1:0] cpu_wrdata_q;
   logic [DATA_BITS-1:0] cpu_rddata_q;
   logic [1:0]           gnt_q;
   logic [2:0]           req;
   logic [2:0]           pick;
   logic                 beat;

   assign req = {bus.cpu_req, bus.mipi_req, bus.fb_req};

   rr_picker3 u_picker (
      .req    (req),
      .urgent (bus.fb_urgent),
      .ptr    (ptr),
      .gnt    (pick)
   );

   // Next state and beat counting; a beat is a returned read word or an accepted write word.
   always_comb begin
      state_nx = state;
      count_nx = count_q;
      beat     = 1'b0;
      case (state)
         S_IDLE: begin
            if (pick[ID_MIPI] || (pick[ID_CPU] && bus.cpu_write)) state_nx = S_WR_BURST;
            else if (pick[ID_FB] || pick[ID_CPU])                 state_nx = S_RD_CMD;
         end
         S_RD_CMD:   if (!bus.mem_wait) state_nx = S_RD_DATA;
         S_RD_DATA:  beat = bus.mem_rdvalid;
         S_WR_BURST: beat = !bus.mem_wait;
         S_DONE:     state_nx = S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
      if (beat) begin
         if (count_q == bc_q - BC_ONE) begin
            count_nx = '0;
            state_nx = S_DONE;
         end else begin
            count_nx = count_q + BC_ONE;
         end
      end
   end

   // State register plus the transaction context latched at grant time.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         count_q      <= '0;
         ptr          <= ID_FB;
         owner        <= ID_FB;
         addr_q       <= '0;
         bc_q         <= '0;
         cpu_wrdata_q <= '0;
         cpu_rddata_q <= '0;
         gnt_q        <= '0;
      end else begin
         state   <= state_nx;
         count_q <= count_nx;
         gnt_q   <= '0;
         if (state == S_IDLE && (|pick)) begin
            gnt_q <= {pick[ID_MIPI], pick[ID_FB]};
            if (pick[ID_FB]) begin
               owner  <= ID_FB;
               addr_q <= bus.fb_addr;
               bc_q   <= BC_FULL;
               ptr    <= ID_MIPI;
            end else if (pick[ID_MIPI]) begin
               owner  <= ID_MIPI;
               addr_q <= bus.mipi_addr;
               bc_q   <= BC_FULL;
               ptr    <= ID_CPU;
            end else begin
               owner        <= ID_CPU;
               addr_q       <= bus.cpu_addr;
               bc_q         <= BC_ONE;
               cpu_wrdata_q <= bus.cpu_wrdata;
               ptr          <= ID_FB;
            end
         end
         if (state == S_RD_DATA && owner == ID_CPU && bus.mem_rdvalid)
            cpu_rddata_q <= bus.mem_rddata;
      end
   end

   // Read beats reach the FB only while its own burst is in the data phase,
   // so stale returns after a reset are dropped.
   assign bus.fb_rdvalid = (state == S_RD_DATA) && (owner == ID_FB) && bus.mem_rdvalid;
   assign bus.fb_rddata  = bus.fb_rdvalid ? bus.mem_rddata : '0;
   assign bus.fb_gnt     = gnt_q[0];
   assign bus.fb_done    = (state == S_DONE) && (owner == ID_FB);

   // MIPI FIFO is show-ahead: its head word is driven straight out and popped by wrack.
   assign bus.mipi_gnt   = gnt_q[1];
   assign bus.mipi_wrack = (state == S_WR_BURST) && (owner == ID_MIPI) && !bus.mem_wait;
   assign bus.mipi_done  = (state == S_DONE) && (owner == ID_MIPI);

   assign bus.cpu_rddata = cpu_rddata_q;
   assign bus.cpu_done   = (state == S_DONE) && (owner == ID_CPU);

   assign bus.mem_addr       = addr_q;
   assign bus.mem_burstcount = bc_q;
   assign bus.mem_read       = (state == S_RD_CMD);
   assign bus.mem_write      = (state == S_WR_BURST);
   assign bus.mem_wrdata     = (state != S_WR_BURST) ? '0 :
                               (owner == ID_MIPI)    ? bus.mipi_wrdata : cpu_wrdata_q;

endmodule

// File: tb/tb_sdram_stream_arbiter.sv
// tb/tb_sdram_stream_arbiter.sv - self-checking bench for sdram_stream_arbiter
module tb_sdram_stream_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   sdram_stream_arbiter_if #(.ADDR_BITS(22), .DATA_BITS(16), .BURST(16)) bus ();

   sdram_stream_arbiter #(.ADDR_BITS(22), .DATA_BITS(16), .BURST(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- memory controller model ----------------
   int          wait_mode = 0;   // 0 none, 1 toggle, 2 random
   logic [15:0] smem [logic [21:0]];
   logic [21:0] rd_q [$];
   logic [15:0] mipi_words [16];
   int          mipi_idx = 0;
   int          wr_cnt = 0, wr_len = 0;
   logic [21:0] wr_base = '0;

   function automatic logic [15:0] init_val(input logic [21:0] a);
      return a[15:0] ^ {a[21:16], 10'h2A5};
   endfunction

   function automatic logic [15:0] sread(input logic [21:0] a);
      return smem.exists(a) ? smem[a] : init_val(a);
   endfunction

   initial begin
      bus.mem_wait    = 1'b0;
      bus.mem_rdvalid = 1'b0;
      bus.mem_rddata  = '0;
      bus.mipi_wrdata = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            wr_cnt = 0;
            mipi_idx = 0;
         end else begin
            if (bus.mem_read && !bus.mem_wait)
               for (int i = 0; i < int'(bus.mem_burstcount); i++) rd_q.push_back(bus.mem_addr + 22'(i));
            if (bus.mem_write && !bus.mem_wait) begin
               if (wr_cnt == 0) begin
                  wr_base = bus.mem_addr;
                  wr_len  = int'(bus.mem_burstcount);
               end
               smem[wr_base + 22'(wr_cnt)] = bus.mem_wrdata;
               wr_cnt++;
               if (wr_cnt >= wr_len) wr_cnt = 0;
            end
            if (bus.mipi_wrack) mipi_idx++;
            if (bus.mipi_done)  mipi_idx = 0;
         end
         @(posedge clk);
         #1;
         case (wait_mode)
            1:       bus.mem_wait = !bus.mem_wait;
            2:       bus.mem_wait = ($urandom_range(0, 3) == 0);
            default: bus.mem_wait = 1'b0;
         endcase
         if (rd_q.size() > 0 && (wait_mode != 2 || $urandom_range(0, 3) != 0)) begin
            bus.mem_rdvalid = 1'b1;
            bus.mem_rddata  = sread(rd_q.pop_front());
         end else begin
            bus.mem_rdvalid = 1'b0;
            bus.mem_rddata  = 16'($urandom);
         end
         bus.mipi_wrdata = mipi_words[mipi_idx % 16];
      end
   end

   // ---------------- output monitor ----------------
   int          cyc = 0;
   int          last_beat_cyc = 0, last_done_cyc = 0, wrack_cnt = 0;
   logic [15:0] fb_beats [$];
   int          done_ids [$];
   logic [15:0] cpu_data [$];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (bus.fb_rdvalid) begin
         fb_beats.push_back(bus.fb_rddata);
         last_beat_cyc = cyc;
      end
      if (bus.mipi_wrack) wrack_cnt++;
      if (bus.fb_done)   begin done_ids.push_back(0); last_done_cyc = cyc; end
      if (bus.mipi_done) begin done_ids.push_back(1); last_done_cyc = cyc; end
      if (bus.cpu_done)  begin done_ids.push_back(2); last_done_cyc = cyc; cpu_data.push_back(bus.cpu_rddata); end
   end

   // ---------------- reference model ----------------
   logic [15:0] ref_mem [logic [21:0]];
   int          mptr = 0;

   function automatic logic [15:0] ref_rd(input logic [21:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   // Winner: urgent FB, else the first pending requester at or after the pointer.
   function automatic int model_pick(input int p, input bit [2:0] pend, input bit urg);
      if (urg && pend[0]) return 0;
      for (int k = 0; k < 3; k++) if (pend[(p + k) % 3]) return (p + k) % 3;
      return -1;
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_dones(input int target, input string tag);
      for (int i = 0; i < 600 && done_ids.size() < target; i++) sample();
      check({tag, "_timeout"}, done_ids.size() >= target, 1);
      drive();
   endtask

   task automatic lone_fb(input logic [21:0] a, input string tag);
      int b0, d0, mism;
      b0 = fb_beats.size();
      d0 = done_ids.size();
      bus.fb_req  = 1'b1;
      bus.fb_addr = a;
      sample();
      check({tag, "_gnt_early"}, bus.fb_gnt, 0);
      drive();
      bus.fb_req = 1'b0;
      sample();
      check({tag, "_gnt"}, bus.fb_gnt, 1);
      check({tag, "_read"}, bus.mem_read, 1);
      check({tag, "_bc"}, bus.mem_burstcount, 16);
      check({tag, "_addr"}, bus.mem_addr, a);
      wait_dones(d0 + 1, tag);
      check({tag, "_beats"}, fb_beats.size() - b0, 16);
      mism = 0;
      for (int i = 0; i < 16 && b0 + i < fb_beats.size(); i++)
         if (fb_beats[b0 + i] !== ref_rd(a + 22'(i))) mism++;
      check({tag, "_data_mism"}, mism, 0);
      check({tag, "_done_id"}, done_ids[d0], 0);
      check({tag, "_done_lat"}, last_done_cyc - last_beat_cyc, 1);
      mptr = 1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int          d0, b0, w0, mism, w;
      int          exp_ids [$];
      bit [2:0]    pend;
      bit          urg, df, dm, dc;
      logic [21:0] fa, ca;

      rst = 1'b1;
      bus.fb_req = 0; bus.fb_urgent = 0; bus.fb_addr = '0;
      bus.mipi_req = 0; bus.mipi_addr = '0;
      bus.cpu_req = 0; bus.cpu_write = 0; bus.cpu_addr = '0; bus.cpu_wrdata = '0;
      for (int i = 0; i < 16; i++) mipi_words[i] = 16'(i);
      repeat (3) drive();
      sample();
      check("rst_ctrl", {bus.fb_gnt, bus.mipi_gnt, bus.mem_read, bus.mem_write, bus.fb_rdvalid,
                         bus.mipi_wrack, bus.fb_done, bus.mipi_done, bus.cpu_done}, 0);
      check("rst_addr", bus.mem_addr, 0);
      check("rst_bc", bus.mem_burstcount, 0);
      check("rst_cpu_rddata", bus.cpu_rddata, 0);
      drive();
      rst = 1'b0;
      mptr = 0;
      drive();

      // lone FB burst, no wait
      lone_fb(22'h000100, "fb1");

      // lone MIPI burst with waitrequest toggling
      wait_mode = 1;
      w0 = wrack_cnt;
      d0 = done_ids.size();
      bus.mipi_req  = 1'b1;
      bus.mipi_addr = 22'h000200;
      sample();
      check("mipi_gnt_early", bus.mipi_gnt, 0);
      drive();
      bus.mipi_req = 1'b0;
      sample();
      check("mipi_gnt", bus.mipi_gnt, 1);
      check("mipi_write", bus.mem_write, 1);
      check("mipi_bc", bus.mem_burstcount, 16);
      check("mipi_first_word", bus.mem_wrdata, 0);
      wait_dones(d0 + 1, "mipi");
      check("mipi_wrack_cnt", wrack_cnt - w0, 16);
      check("mipi_done_id", done_ids[d0], 1);
      mism = 0;
      for (int i = 0; i < 16; i++) begin
         ref_mem[22'h000200 + 22'(i)] = 16'(i);
         if (sread(22'h000200 + 22'(i)) !== 16'(i)) mism++;
      end
      check("mipi_mem_mism", mism, 0);
      mptr = 2;

      // all three requesting continuously from reset, random waits
      rst = 1'b1;
      drive();
      drive();
      rst = 1'b0;
      mptr = 0;
      wait_mode = 2;
      fa = 22'($urandom) & 22'h3FFFF0 | 22'h100000;
      ca = 22'h010000 | 22'($urandom_range(0, 16'hFFFF));
      for (int i = 0; i < 16; i++) mipi_words[i] = 16'($urandom);
      pend = 3'b111;
      exp_ids.delete();
      for (int t = 0; t < 6; t++) begin
         w = model_pick(mptr, pend, 1'b0);
         exp_ids.push_back(w);
         mptr = (w + 1) % 3;
      end
      b0 = fb_beats.size();
      d0 = done_ids.size();
      w0 = cpu_data.size();
      bus.fb_addr = fa; bus.fb_req = 1;
      bus.mipi_addr = 22'h000300; bus.mipi_req = 1;
      bus.cpu_addr = ca; bus.cpu_write = 0; bus.cpu_req = 1;
      for (int i = 0; i < 2000 && done_ids.size() < d0 + 6; i++) sample();
      check("rr_timeout", done_ids.size() >= d0 + 6, 1);
      drive();
      bus.fb_req = 0; bus.mipi_req = 0; bus.cpu_req = 0;
      for (int t = 0; t < 6 && d0 + t < done_ids.size(); t++)
         check($sformatf("rr_order_%0d", t), done_ids[d0 + t], exp_ids[t]);
      check("rr_fb_beats", fb_beats.size() - b0, 32);
      mism = 0;
      for (int i = 0; i < 32 && b0 + i < fb_beats.size(); i++)
         if (fb_beats[b0 + i] !== ref_rd(fa + 22'(i % 16))) mism++;
      check("rr_fb_data_mism", mism, 0);
      check("rr_cpu_cnt", cpu_data.size() - w0, 2);
      if (cpu_data.size() > 0) check("rr_cpu_data", cpu_data[cpu_data.size() - 1], ref_rd(ca));
      for (int i = 0; i < 16; i++) ref_mem[22'h000300 + 22'(i)] = mipi_words[i];
      repeat (3) drive();

      // pointer to MIPI, then FB urgent beats the pointer
      lone_fb(22'($urandom) & 22'h3FFFF0, "fb2");
      pend = 3'b111;
      urg  = 1'b1;
      exp_ids.delete();
      for (int t = 0; t < 3; t++) begin
         w = model_pick(mptr, pend, urg);
         exp_ids.push_back(w);
         mptr = (w + 1) % 3;
         pend[w] = 1'b0;
         if (w == 0) urg = 1'b0;
      end
      d0 = done_ids.size();
      bus.fb_req = 1; bus.fb_urgent = 1; bus.fb_addr = 22'h000500;
      bus.mipi_req = 1; bus.mipi_addr = 22'h000600;
      bus.cpu_req = 1; bus.cpu_write = 0; bus.cpu_addr = ca;
      for (int i = 0; i < 2000 && done_ids.size() < d0 + 3; i++) begin
         sample();
         df = bus.fb_gnt; dm = bus.mipi_gnt; dc = bus.cpu_done;
         drive();
         if (df) begin bus.fb_req = 0; bus.fb_urgent = 0; end
         if (dm) bus.mipi_req = 0;
         if (dc) bus.cpu_req = 0;
      end
      check("urg_timeout", done_ids.size() >= d0 + 3, 1);
      bus.fb_req = 0; bus.fb_urgent = 0; bus.mipi_req = 0; bus.cpu_req = 0;
      for (int t = 0; t < 3 && d0 + t < done_ids.size(); t++)
         check($sformatf("urg_order_%0d", t), done_ids[d0 + t], exp_ids[t]);
      for (int i = 0; i < 16; i++) ref_mem[22'h000600 + 22'(i)] = mipi_words[i];
      repeat (2) drive();

      // CPU write then read at the top address
      d0 = done_ids.size();
      bus.cpu_req = 1; bus.cpu_write = 1; bus.cpu_addr = 22'h3FFFFF; bus.cpu_wrdata = 16'hA5A5;
      sample();
      check("cpuw_early", bus.mem_write, 0);
      drive();
      bus.cpu_req = 0;
      sample();
      check("cpuw_write", bus.mem_write, 1);
      check("cpuw_bc", bus.mem_burstcount, 1);
      check("cpuw_addr", bus.mem_addr, 22'h3FFFFF);
      check("cpuw_data", bus.mem_wrdata, 16'hA5A5);
      wait_dones(d0 + 1, "cpuw");
      check("cpuw_done_id", done_ids[d0], 2);
      ref_mem[22'h3FFFFF] = 16'hA5A5;
      mptr = 0;
      w0 = cpu_data.size();
      bus.cpu_req = 1; bus.cpu_write = 0;
      drive();
      bus.cpu_req = 0;
      sample();
      check("cpur_read", bus.mem_read, 1);
      check("cpur_bc", bus.mem_burstcount, 1);
      wait_dones(d0 + 2, "cpur");
      check("cpur_cnt", cpu_data.size() - w0, 1);
      if (cpu_data.size() > w0) check("cpur_data", cpu_data[w0], ref_rd(22'h3FFFFF));
      drive();

      // reset in the middle of an FB burst
      wait_mode = 0;
      b0 = fb_beats.size();
      fa = 22'h000700;
      bus.fb_req = 1; bus.fb_addr = fa;
      drive();
      bus.fb_req = 0;
      for (int i = 0; i < 200 && fb_beats.size() < b0 + 6; i++) sample();
      check("rstb_reach", fb_beats.size() >= b0 + 6, 1);
      drive();
      rst = 1'b1;
      drive();
      sample();
      check("rstb_ctrl", {bus.fb_rdvalid, bus.fb_gnt, bus.fb_done, bus.mem_read, bus.mem_write,
                          bus.mipi_wrack, bus.cpu_done}, 0);
      check("rstb_rddata", bus.fb_rddata, 0);
      check("rstb_addr", bus.mem_addr, 0);
      check("rstb_cpu_rddata", bus.cpu_rddata, 0);
      drive();
      rst = 1'b0;
      mptr = 0;
      for (int i = 0; i < 200 && rd_q.size() > 0; i++) sample();
      repeat (2) sample();
      check("rstb_beats", fb_beats.size() - b0, 7);
      drive();
      wait_mode = 2;
      lone_fb(22'h000840, "fb3");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
